// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised up/down counter with terminal count, load/clear, wrap/saturate and boundary pulses
module updown_counter #(
   parameter int REGISTER_SIZE = 4,
   parameter int MAX_COUNT     = 2**REGISTER_SIZE - 1,
   parameter bit SATURATE      = 1'b0
) (
   input  logic                     control_clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     load,
   input  logic [REGISTER_SIZE-1:0] load_value,
   input  logic                     enable,
   input  logic                     up_down,
   output logic [REGISTER_SIZE-1:0] counter_out,
   output logic                     overflow_flag,
   output logic                     underflow_flag,
   output logic                     at_max,
   output logic                     at_zero
);

   localparam logic [REGISTER_SIZE-1:0] C_MAX  = REGISTER_SIZE'(MAX_COUNT);
   localparam logic [REGISTER_SIZE-1:0] C_ZERO = '0;
   localparam logic [REGISTER_SIZE-1:0] C_ONE  = REGISTER_SIZE'(1);

   logic [REGISTER_SIZE-1:0] r_count;
   logic                     r_overflow;
   logic                     r_underflow;

   logic [REGISTER_SIZE-1:0] w_load_clamped;
   logic [REGISTER_SIZE-1:0] w_count_next;
   logic                     w_overflow_next;
   logic                     w_underflow_next;
   logic                     w_at_max;
   logic                     w_at_zero;

   assign w_at_max       = (r_count == C_MAX);
   assign w_at_zero      = (r_count == C_ZERO);
   // Out-of-range load values are pinned to the terminal count so the
   // counter can never sit above MAX_COUNT.
   assign w_load_clamped = (load_value > C_MAX) ? C_MAX : load_value;

   // Next-state selection: clear beats load beats enable; flags drop on any
   // edge that is not itself a boundary event.
   always_comb begin
      w_count_next     = r_count;
      w_overflow_next  = 1'b0;
      w_underflow_next = 1'b0;
      if (clear) begin
         w_count_next = C_ZERO;
      end else if (load) begin
         w_count_next = w_load_clamped;
      end else if (enable) begin
         if (up_down) begin
            if (w_at_max) begin
               w_overflow_next = 1'b1;
               w_count_next    = SATURATE ? r_count : C_ZERO;
            end else begin
               w_count_next = r_count + C_ONE;
            end
         end else begin
            if (w_at_zero) begin
               w_underflow_next = 1'b1;
               w_count_next     = SATURATE ? r_count : C_MAX;
            end else begin
               w_count_next = r_count - C_ONE;
            end
         end
      end
   end

   // Count and boundary-pulse registers, cleared asynchronously by reset.
   always_ff @(posedge control_clock or negedge reset) begin
      if (!reset) begin
         r_count     <= C_ZERO;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_next;
         r_overflow  <= w_overflow_next;
         r_underflow <= w_underflow_next;
      end
   end

   assign counter_out    = r_count;
   assign overflow_flag  = r_overflow;
   assign underflow_flag = r_underflow;
   assign at_max         = w_at_max;
   assign at_zero        = w_at_zero;

endmodule
